// File: rtl/mem_pkg.sv
// Shared types for the memory issue controller: bus sizes, FSM states,
// latched request and response records.
package mem_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned PREG_W = 6;
    typedef logic [PREG_W-1:0] preg_addr_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } mem_state_t;

    typedef struct packed {
        logic       write;
        mem_size_t  size;
        logic       is_unsigned;
        word_t      addr;
        word_t      wdata;
        preg_addr_t preg;
    } mem_req_t;

    typedef struct packed {
        word_t      data;
        preg_addr_t preg;
        logic       adel;
        logic       ades;
    } mem_resp_t;

    // Raw size code 3 is illegal and handled as a word access.
    function automatic mem_size_t decode_size(input logic [1:0] raw);
        return (raw == 2'd3) ? SZ_WORD : mem_size_t'(raw);
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational data alignment: store lane replication and misalignment
// check on the issuing request, load lane extraction and extension on the
// bus return data of the in-flight request.
module mem_align
    import mem_pkg::*;
(
    input  mem_size_t   iss_size,
    input  word_t       iss_addr,
    input  word_t       iss_wdata,
    output word_t       bus_wdata,
    output logic        misaligned,
    input  mem_size_t   ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_offset,
    input  word_t       ld_rdata,
    output word_t       ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Replicate store data across the lanes and flag unaligned addresses
    always_comb begin
        bus_wdata  = iss_wdata;
        misaligned = 1'b0;
        unique case (iss_size)
            SZ_BYTE: begin
                bus_wdata = {4{iss_wdata[7:0]}};
            end
            SZ_HALF: begin
                bus_wdata  = {2{iss_wdata[15:0]}};
                misaligned = iss_addr[0];
            end
            default: begin
                bus_wdata  = iss_wdata;
                misaligned = (iss_addr[1:0] != 2'b00);
            end
        endcase
    end

    // Pick the addressed lane from return data and sign/zero-extend it
    always_comb begin
        ld_byte = ld_rdata[7:0];
        ld_half = ld_offset[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        unique case (ld_offset)
            2'd0: ld_byte = ld_rdata[7:0];
            2'd1: ld_byte = ld_rdata[15:8];
            2'd2: ld_byte = ld_rdata[23:16];
            default: ld_byte = ld_rdata[31:24];
        endcase
        unique case (ld_size)
            SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_issue_ctrl.sv
// Memory-access controller: accepts one memory op from issue, runs the
// SRAM-like req/addr_ok/data_ok handshake, and returns one tagged response
// per op. A flush withdraws an unaccepted request or drains an accepted one.
module mem_issue_ctrl
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       flush,
    input  logic       mem_issued,
    input  logic       req_write,
    input  logic [1:0] req_size,
    input  logic       req_unsigned,
    input  word_t      req_addr,
    input  word_t      req_wdata,
    input  preg_addr_t req_preg,
    output logic       wait_mem,
    output logic       data_req,
    output logic       data_wr,
    output logic [1:0] data_size,
    output word_t      data_addr,
    output word_t      data_wdata,
    input  logic       data_addr_ok,
    input  logic       data_ok,
    input  word_t      data_rdata,
    output logic       resp_valid,
    output word_t      resp_data,
    output preg_addr_t resp_preg,
    output logic       resp_adel,
    output logic       resp_ades
);

    mem_state_t state, state_nx;
    mem_req_t   cur;
    mem_resp_t  resp_q;
    mem_size_t  iss_size;
    word_t      iss_wdata_rep;
    word_t      ld_data;
    logic       iss_misaligned;
    logic       accept;
    logic       bus_done;

    assign iss_size = decode_size(req_size);

    mem_align u_align (
        .iss_size    (iss_size),
        .iss_addr    (req_addr),
        .iss_wdata   (req_wdata),
        .bus_wdata   (iss_wdata_rep),
        .misaligned  (iss_misaligned),
        .ld_size     (cur.size),
        .ld_unsigned (cur.is_unsigned),
        .ld_offset   (cur.addr[1:0]),
        .ld_rdata    (data_rdata),
        .ld_data     (ld_data)
    );

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, handshake decode, back-pressure and response strobe
    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        bus_done   = 1'b0;
        resp_valid = 1'b0;
        wait_mem   = mem_issued | (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (mem_issued && !flush) begin
                    accept   = 1'b1;
                    state_nx = iss_misaligned ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                // An accepted request whose data also returns this cycle
                // has nothing left to drain.
                if (flush) begin
                    state_nx = (data_addr_ok && !data_ok) ? S_DRAIN : S_IDLE;
                end else if (data_addr_ok) begin
                    bus_done = data_ok;
                    state_nx = data_ok ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    state_nx = data_ok ? S_IDLE : S_DRAIN;
                end else if (data_ok) begin
                    bus_done = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                resp_valid = !flush;
                state_nx   = S_IDLE;
            end
            S_DRAIN: begin
                if (data_ok) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Latch the accepted request for load alignment and store detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur <= '0;
        end else if (accept) begin
            cur.write       <= req_write;
            cur.size        <= iss_size;
            cur.is_unsigned <= req_unsigned;
            cur.addr        <= req_addr;
            cur.wdata       <= req_wdata;
            cur.preg        <= req_preg;
        end
    end

    // Bus request registers: payload loaded at issue, request follows FSM
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_req   <= 1'b0;
            data_wr    <= 1'b0;
            data_size  <= '0;
            data_addr  <= '0;
            data_wdata <= '0;
        end else begin
            data_req <= (state_nx == S_REQ);
            if (accept) begin
                data_wr    <= req_write;
                data_size  <= iss_size;
                data_addr  <= req_addr;
                data_wdata <= iss_wdata_rep;
            end
        end
    end

    // Response record: exception info at issue, load data at completion
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_q <= '0;
        end else if (accept) begin
            resp_q.preg <= req_preg;
            resp_q.adel <= iss_misaligned & ~req_write;
            resp_q.ades <= iss_misaligned & req_write;
            resp_q.data <= iss_misaligned ? req_addr : '0;
        end else if (bus_done) begin
            resp_q.data <= cur.write ? '0 : ld_data;
        end
    end

    assign resp_data = resp_q.data;
    assign resp_preg = resp_q.preg;
    assign resp_adel = resp_q.adel;
    assign resp_ades = resp_q.ades;

endmodule
